mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the pipelined CPU's instruction-fetch (I) side and data (D) side.
- Each side issues a request, which the arbiter grants, sequences through a fixed-latency memory access, and completes with a one-cycle done pulse.
- Sits between the CPU memory interfaces and the memory model; the CPU stalls on the outstanding side until its done pulse arrives.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/arb_priority_select.sv | 25 ++
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and widths for the I/D memory port arbiter
package mem_port_arbiter_pkg;

    localparam int MPA_WORD_SIZE = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/arb_priority_select.sv
// rtl/arb_priority_select.sv - D-over-I grant policy with optional streak override
// Optional feature macro: STARVATION_GUARD_EN
module arb_priority_select (
    input  logic i_req,
    input  logic d_req,
`ifdef STARVATION_GUARD_EN
    input  logic streak_full,
`endif
    output logic grant_i,
    output logic grant_d
);

    always_comb begin
        grant_d = d_req;
        grant_i = i_req & ~d_req;
`ifdef STARVATION_GUARD_EN
        // D has had its fill of consecutive grants while I waited; let I through once
        if (streak_full && i_req && d_req) begin
            grant_i = 1'b1;
            grant_d = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency single-port memory between CPU I and D sides
// Optional feature macro: STARVATION_GUARD_EN
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_SIZE    = MPA_WORD_SIZE,
    parameter int LATENCY      = 2,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_done,
    output logic [WORD_SIZE-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_done,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy
);

    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15 || MAX_D_STREAK < 1) begin : g_bad_params
        $error("mem_port_arbiter: LATENCY must be 1..15 and MAX_D_STREAK at least 1");
    end

    state_t                 state_q, state_d;
    owner_t                 owner_q, owner_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   mem_we_q, mem_we_d;
    logic [WORD_SIZE-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0]   mem_wdata_q, mem_wdata_d;
    logic [WORD_SIZE-1:0]   i_rdata_q, i_rdata_d;
    logic [WORD_SIZE-1:0]   d_rdata_q, d_rdata_d;
    logic                   grant_i, grant_d;

`ifdef STARVATION_GUARD_EN
    localparam int SW = $clog2(MAX_D_STREAK + 1);

    logic [SW-1:0] d_streak_q, d_streak_d;
    logic          streak_full;

    assign streak_full = (d_streak_q == SW'(MAX_D_STREAK));

    // Only grants made while I is actually waiting count toward the streak
    always_comb begin
        d_streak_d = d_streak_q;
        if (state_q == ST_IDLE) begin
            if (grant_i) begin
                d_streak_d = '0;
            end else if (grant_d) begin
                d_streak_d = i_req ? d_streak_q + SW'(1) : '0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            d_streak_q <= '0;
        end else begin
            d_streak_q <= d_streak_d;
        end
    end
`endif

    arb_priority_select u_select (
        .i_req       (i_req),
        .d_req       (d_req),
`ifdef STARVATION_GUARD_EN
        .streak_full (streak_full),
`endif
        .grant_i     (grant_i),
        .grant_d     (grant_d)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_d) begin
                    state_d     = ST_ACCESS;
                    owner_d     = OWN_D;
                    cnt_d       = '0;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (grant_i) begin
                    state_d     = ST_ACCESS;
                    owner_d     = OWN_I;
                    cnt_d       = '0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_addr;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_RESP;
                    // Drop write enable as the access ends so no stray write leaks into RESP
                    mem_we_d = 1'b0;
                    if (owner_q == OWN_I) begin
                        i_rdata_d = mem_rdata;
                    end else if (owner_q == OWN_D && !mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = (state_q == ST_ACCESS);
    assign busy      = (state_q != ST_IDLE);
    assign i_done    = (state_q == ST_RESP) && (owner_q == OWN_I);
    assign d_done    = (state_q == ST_RESP) && (owner_q == OWN_D);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - transaction-level checked bench for the I/D memory port arbiter
module tb_mem_port_arbiter;

    localparam int W    = 16;
    localparam int LAT  = 2;
    localparam int MAXS = 4;

    logic         Clk;
    logic         Reset;
    logic         i_req;
    logic [W-1:0] i_addr;
    logic         i_done;
    logic [W-1:0] i_rdata;
    logic         d_req;
    logic         d_we;
    logic [W-1:0] d_addr;
    logic [W-1:0] d_wdata;
    logic         d_done;
    logic [W-1:0] d_rdata;
    logic         mem_req;
    logic         mem_we;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;
    logic         busy;

    mem_port_arbiter #(
        .WORD_SIZE    (W),
        .LATENCY      (LAT),
        .MAX_D_STREAK (MAXS)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [W-1:0] init_word(input logic [7:0] a);
        return {a, ~a} ^ 16'h3C5A;
    endfunction

    // Memory the arbiter talks to; aliases on the low address byte
    logic [W-1:0] mem_arr [256];
    bit           written [256];

    always @(posedge Clk) begin
        if (mem_req && mem_we) begin
            mem_arr[mem_addr[7:0]] <= mem_wdata;
            written[mem_addr[7:0]] <= 1'b1;
        end
    end

    assign mem_rdata = written[mem_addr[7:0]] ? mem_arr[mem_addr[7:0]] : init_word(mem_addr[7:0]);

    // Reference model state
    logic [W-1:0] ref_mem [256];
    logic [W-1:0] exp_i_rdata;
    logic [W-1:0] exp_d_rdata;
    int           streak;

    int n_assert;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        streak = 0;
    endtask

    // Serve n_i fetches and n_d data accesses with both requests held until the
    // side's last completion; predicted schedule comes from the grant rules alone.
    task automatic run(input string tag, input int n_i, input int n_d,
                       input logic [W-1:0] ia, input logic [W-1:0] da,
                       input logic dwe, input logic [W-1:0] dwd);
        int sched[$];
        int ri;
        int rd;
        int total;
        bit pick_d;
        ri = n_i;
        rd = n_d;
        while (ri > 0 || rd > 0) begin
            pick_d = (rd > 0);
`ifdef STARVATION_GUARD_EN
            if (ri > 0 && rd > 0 && streak == MAXS) pick_d = 1'b0;
            if (pick_d) streak = (ri > 0) ? streak + 1 : 0;
            else streak = 0;
`endif
            if (pick_d) begin sched.push_back(2); rd--; end
            else begin sched.push_back(1); ri--; end
        end
        total = sched.size() * (LAT + 2);

        i_req   = (n_i > 0);
        i_addr  = ia;
        d_req   = (n_d > 0);
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
        ri = n_i;
        rd = n_d;

        for (int c = 0; c < total; c++) begin
            int  k;
            int  ph;
            int  own;
            bit  e_req;
            k   = c / (LAT + 2);
            ph  = c % (LAT + 2);
            own = sched[k];
            e_req = (ph >= 1 && ph <= LAT);
            if (ph == LAT + 1) begin
                if (own == 1) begin
                    exp_i_rdata = ref_mem[ia[7:0]];
                end else if (dwe) begin
                    ref_mem[da[7:0]] = dwd;
                end else begin
                    exp_d_rdata = ref_mem[da[7:0]];
                end
            end
            @(negedge Clk);
            chk({tag, ".mem_req"}, 32'(mem_req), 32'(e_req));
            chk({tag, ".busy"},    32'(busy),    32'(ph != 0));
            chk({tag, ".i_done"},  32'(i_done),  32'(ph == LAT + 1 && own == 1));
            chk({tag, ".d_done"},  32'(d_done),  32'(ph == LAT + 1 && own == 2));
            chk({tag, ".i_rdata"}, 32'(i_rdata), 32'(exp_i_rdata));
            chk({tag, ".d_rdata"}, 32'(d_rdata), 32'(exp_d_rdata));
            if (e_req) begin
                chk({tag, ".mem_addr"}, 32'(mem_addr), 32'((own == 1) ? ia : da));
                chk({tag, ".mem_we"},   32'(mem_we),   32'((own == 2) && dwe));
                if (own == 2 && dwe) chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(dwd));
            end
            @(posedge Clk);
            #1;
            if (ph == LAT + 1) begin
                if (own == 1) begin ri--; if (ri == 0) i_req = 1'b0; end
                else begin rd--; if (rd == 0) d_req = 1'b0; end
            end
        end
        @(negedge Clk);
        chk({tag, ".idle_after"}, 32'(busy), 32'(0));
        @(posedge Clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        Reset    = 1'b1;
        i_req    = 1'b0;
        i_addr   = '0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));

        @(posedge Clk);
        @(negedge Clk);
        chk("rst.mem_req",   32'(mem_req),   32'(0));
        chk("rst.mem_we",    32'(mem_we),    32'(0));
        chk("rst.mem_addr",  32'(mem_addr),  32'(0));
        chk("rst.mem_wdata", 32'(mem_wdata), 32'(0));
        chk("rst.i_done",    32'(i_done),    32'(0));
        chk("rst.d_done",    32'(d_done),    32'(0));
        chk("rst.i_rdata",   32'(i_rdata),   32'(0));
        chk("rst.d_rdata",   32'(d_rdata),   32'(0));
        chk("rst.busy",      32'(busy),      32'(0));
        do_reset();

        run("d_store_abcd", 0, 1, 16'h0000, 16'h0010, 1'b1, 16'hABCD);
        run("i_fetch",      1, 0, 16'h0010, 16'h0000, 1'b0, 16'h0000);
        run("d_store",      0, 1, 16'h0000, 16'h0020, 1'b1, 16'h1234);
        run("d_load",       0, 1, 16'h0000, 16'h0020, 1'b0, 16'h0000);
        run("both_same",    1, 1, 16'h0030, 16'h0040, 1'b0, 16'h0000);
        run("store_fetch",  1, 1, 16'h0020, 16'h0020, 1'b1, 16'h5A5A);
        run("i_back2back",  2, 0, 16'h0050, 16'h0000, 1'b0, 16'h0000);
        run("d_back2back",  0, 2, 16'h0000, 16'h0060, 1'b0, 16'h0000);
        run("starve_a",     1, 6, 16'h0070, 16'h0080, 1'b0, 16'h0000);
        run("starve_b",     2, 9, 16'h0071, 16'h0081, 1'b1, 16'h0F0F);

        // Reset lands during ACCESS of a D load: access abandoned, no done
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0005;
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(negedge Clk);
        chk("rst_mid.in_access", 32'(mem_req), 32'(1));
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        d_req = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        streak = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            chk("rst_mid.mem_req", 32'(mem_req), 32'(0));
            chk("rst_mid.busy",    32'(busy),    32'(0));
            chk("rst_mid.d_done",  32'(d_done),  32'(0));
            chk("rst_mid.d_rdata", 32'(d_rdata), 32'(0));
            @(posedge Clk);
            #1;
        end

        for (int t = 0; t < 40; t++) begin
            int ni;
            int nd;
            ni = $urandom_range(0, 2);
            nd = $urandom_range(0, 3);
            if (ni == 0 && nd == 0) nd = 1;
            run("rand", ni, nd,
                {8'($urandom), 8'($urandom_range(0, 15))},
                {8'($urandom), 8'($urandom_range(0, 15))},
                1'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
